// File: rtl/bram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package  : bram_arbiter_pkg
// Brief    : Shared widths, FSM state type and BRAM address split helpers.
// Revision : 1.0
// ============================================================================
package bram_arbiter_pkg;

  localparam int ADDR_W     = 14;
  localparam int DATA_W     = 4;
  localparam int BRAM_DEPTH = 16384;
  localparam int BRAM_AW    = 9;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // The BRAM macro takes the low word address on RWADDR and the high bits on RADDR.
  function automatic logic [BRAM_AW-1:0] bram_rwaddr(input logic [ADDR_W-1:0] addr);
    return addr[BRAM_AW-1:0];
  endfunction

  function automatic logic [BRAM_AW-1:0] bram_raddr(input logic [ADDR_W-1:0] addr);
    return {4'b0000, addr[ADDR_W-1:BRAM_AW]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/bram_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Round-robin one-hot grant; pointer moves to the winner on a grant.
// Revision : 1.0
// ============================================================================
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  localparam int PTR_W = $clog2(N);

  logic [PTR_W-1:0] last;
  logic [PTR_W-1:0] cand;
  logic [PTR_W-1:0] grant_idx;
  logic             found;

  // Search starts one past the last winner, so the last winner has lowest priority.
  always_comb begin
    grant     = '0;
    grant_idx = last;
    cand      = '0;
    found     = 1'b0;
    for (int k = 1; k <= N; k++) begin
      cand = PTR_W'((int'(last) + k) % N);
      if (!found && req[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
    if (found) begin
      grant[grant_idx] = 1'b1;
    end
  end

  // The caller only presents requests it can accept, so a grant is a transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      last <= PTR_W'(N - 1);
    end else if (found) begin
      last <= grant_idx;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bram_arbiter
// Brief    : N-requester round-robin front end for one single-port BRAM.
//            Define BRAM_ARBITER_INIT_EN to clear the whole BRAM after reset.
// Revision : 1.0
// ============================================================================
module bram_arbiter
  import bram_arbiter_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [N_REQ-1:0]        REQ_VALID,
  output logic [N_REQ-1:0]        REQ_READY,
  input  logic [N_REQ-1:0]        REQ_WE,
  input  logic [N_REQ*ADDR_W-1:0] REQ_ADDR,
  input  logic [N_REQ*DATA_W-1:0] REQ_DIN,
  output logic [N_REQ-1:0]        RSP_VALID,
  output logic [DATA_W-1:0]       RSP_DATA,
  output logic                    INIT_DONE,
  output logic                    BRAM_WE,
  output logic [BRAM_AW-1:0]      BRAM_RWADDR,
  output logic [BRAM_AW-1:0]      BRAM_RADDR,
  output logic [DATA_W-1:0]       BRAM_DIN,
  input  logic [DATA_W-1:0]       BRAM_DOUT
);

`ifdef BRAM_ARBITER_INIT_EN
  localparam state_t RESET_STATE = INIT;
`else
  localparam state_t RESET_STATE = RUN;
`endif

  state_t             state;
  state_t             state_nxt;
  logic               accept_en;
  logic [N_REQ-1:0]   arb_req;
  logic [N_REQ-1:0]   grant;
  logic               transfer;

  logic               cmd_we;
  logic [ADDR_W-1:0]  cmd_addr;
  logic [DATA_W-1:0]  cmd_din;

  logic               s1_we;
  logic [BRAM_AW-1:0] s1_rwaddr;
  logic [BRAM_AW-1:0] s1_raddr;
  logic [DATA_W-1:0]  s1_din;
  logic [N_REQ-1:0]   s1_rd;

  logic [N_REQ-1:0]   rsp_valid;
  logic [DATA_W-1:0]  rsp_data;

`ifdef BRAM_ARBITER_INIT_EN
  logic [ADDR_W-1:0]  clr_cnt;
  logic               clr_last;

  assign clr_last = (clr_cnt == ADDR_W'(BRAM_DEPTH - 1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      clr_cnt <= '0;
    end else if (state == INIT) begin
      clr_cnt <= clr_cnt + ADDR_W'(1);
    end
  end
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= RESET_STATE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
`ifdef BRAM_ARBITER_INIT_EN
    if (state == INIT && clr_last) begin
      state_nxt = RUN;
    end
`else
    state_nxt = RUN;
`endif
  end

  // Requests are masked here so READY is zero in reset and during the clear.
  assign accept_en = (state == RUN) && !RST;
  assign arb_req   = REQ_VALID & {N_REQ{accept_en}};

  rr_arbiter #(
    .N (N_REQ)
  ) u_rr (
    .clk   (CLK),
    .rst   (RST),
    .req   (arb_req),
    .grant (grant)
  );

  assign REQ_READY = grant;
  assign transfer  = |grant;
  assign INIT_DONE = (state == RUN) && !RST;

  always_comb begin
    cmd_we   = 1'b0;
    cmd_addr = '0;
    cmd_din  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        cmd_we   = REQ_WE[i];
        cmd_addr = REQ_ADDR[i*ADDR_W +: ADDR_W];
        cmd_din  = REQ_DIN[i*DATA_W +: DATA_W];
      end
    end
  end

  // Stage 1: drive the BRAM pins; addresses hold when idle so the async read is stable.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_we     <= 1'b0;
      s1_rwaddr <= '0;
      s1_raddr  <= '0;
      s1_din    <= '0;
      s1_rd     <= '0;
    end
`ifdef BRAM_ARBITER_INIT_EN
    else if (state == INIT) begin
      s1_we     <= 1'b1;
      s1_rwaddr <= bram_rwaddr(clr_cnt);
      s1_raddr  <= bram_raddr(clr_cnt);
      s1_din    <= '0;
      s1_rd     <= '0;
    end
`endif
    else if (transfer) begin
      s1_we     <= cmd_we;
      s1_rwaddr <= bram_rwaddr(cmd_addr);
      s1_raddr  <= bram_raddr(cmd_addr);
      if (cmd_we) begin
        s1_din <= cmd_din;
      end
      s1_rd     <= cmd_we ? '0 : grant;
    end else begin
      s1_we <= 1'b0;
      s1_rd <= '0;
    end
  end

  // Stage 2: capture the asynchronous BRAM read data at the end of stage 1.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= s1_rd;
      if (|s1_rd) begin
        rsp_data <= BRAM_DOUT;
      end
    end
  end

  assign BRAM_WE     = s1_we;
  assign BRAM_RWADDR = s1_rwaddr;
  assign BRAM_RADDR  = s1_raddr;
  assign BRAM_DIN    = s1_din;
  assign RSP_VALID   = rsp_valid;
  assign RSP_DATA    = rsp_data;

endmodule
`default_nettype wire
